// File: rtl/wb_pkg.sv
// Shared widths and the load-queue entry layout for the register-file
// write-back controller.
package wb_pkg;

    localparam int XLEN          = 32;
    localparam int AW            = 5;
    localparam int DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic            live;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    // True when a destination address names the hard-wired zero register.
    function automatic logic is_x0(input logic [AW-1:0] addr);
        return (addr == {AW{1'b0}});
    endfunction

endpackage

// File: rtl/wb_load_queue.sv
// Circular buffer of pending load write-backs with kill-by-destination and
// two hazard query ports over the live entries.
module wb_load_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic [AW-1:0]   push_rd,
    input  logic [XLEN-1:0] push_data,
    input  logic            pop,
    input  logic            kill_en,
    input  logic [AW-1:0]   kill_rd,
    input  logic [AW-1:0]   q1_rd,
    input  logic [AW-1:0]   q2_rd,
    output logic [PW:0]     count,
    output logic            head_live,
    output logic [AW-1:0]   head_rd,
    output logic [XLEN-1:0] head_data,
    output logic            pend1,
    output logic            pend2
);

    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    wb_entry_t     mem_r [DEPTH];
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [PW:0]   count_r;
    logic          pend1_s;
    logic          pend2_s;

    // Entry storage and pointers. Kill is applied before the push so that a
    // load arriving on the killing edge stays live.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {(PW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{live: 1'b0, rd: {AW{1'b0}}, data: {XLEN{1'b0}}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && (mem_r[i].rd == kill_rd)) begin
                    mem_r[i].live <= 1'b0;
                end
            end
            if (pop) begin
                mem_r[head_r].live <= 1'b0;
                head_r             <= head_r + PTR_ONE;
            end
            if (push) begin
                mem_r[tail_r] <= '{live: 1'b1, rd: push_rd, data: push_data};
                tail_r        <= tail_r + PTR_ONE;
            end
            count_r <= count_r + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // Hazard match over live entries only; popped slots are already dead.
    always_comb begin
        pend1_s = 1'b0;
        pend2_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            pend1_s = pend1_s | (mem_r[i].live && (mem_r[i].rd == q1_rd));
            pend2_s = pend2_s | (mem_r[i].live && (mem_r[i].rd == q2_rd));
        end
        if (is_x0(q1_rd)) begin
            pend1_s = 1'b0;
        end else begin
            pend1_s = pend1_s;
        end
        if (is_x0(q2_rd)) begin
            pend2_s = 1'b0;
        end else begin
            pend2_s = pend2_s;
        end
    end

    assign count     = count_r;
    assign head_live = mem_r[head_r].live;
    assign head_rd   = mem_r[head_r].rd;
    assign head_data = mem_r[head_r].data;
    assign pend1     = pend1_s;
    assign pend2     = pend2_s;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port controller: ALU results win the port, queued
// loads drain when the ALU is idle or targets x0.
module regfile_wb_ctrl
    import wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [AW-1:0]   ld_rd,
    input  logic [XLEN-1:0] ld_data,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            pend1,
    output logic            pend2,
    output logic [AW-1:0]   rd,
    output logic [XLEN-1:0] write_data,
    output logic            RegWrite,
    output logic            wb_idle
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    logic [PW:0]     count_s;
    logic            head_live_s;
    logic [AW-1:0]   head_rd_s;
    logic [XLEN-1:0] head_data_s;
    logic            ld_ready_s;
    logic            alu_issue_s;
    logic            push_s;
    logic            pop_s;
    logic [AW-1:0]   rd_r;
    logic [XLEN-1:0] write_data_r;
    logic            reg_write_r;

    // Readiness looks only at registered occupancy, so a full queue refuses
    // a load even on a cycle that also pops.
    assign ld_ready_s  = !reset && (count_s < FULL_COUNT);
    assign alu_issue_s = alu_valid && !is_x0(alu_rd);
    assign push_s      = ld_valid && ld_ready_s && !is_x0(ld_rd);
    assign pop_s       = !alu_issue_s && (count_s != {(PW+1){1'b0}});

    wb_load_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_rd   (ld_rd),
        .push_data (ld_data),
        .pop       (pop_s),
        .kill_en   (alu_issue_s),
        .kill_rd   (alu_rd),
        .q1_rd     (rs1),
        .q2_rd     (rs2),
        .count     (count_s),
        .head_live (head_live_s),
        .head_rd   (head_rd_s),
        .head_data (head_data_s),
        .pend1     (pend1),
        .pend2     (pend2)
    );

    // Write-port registers; a killed head is consumed without a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_write_r  <= 1'b0;
            rd_r         <= {AW{1'b0}};
            write_data_r <= {XLEN{1'b0}};
        end else if (alu_issue_s) begin
            reg_write_r  <= 1'b1;
            rd_r         <= alu_rd;
            write_data_r <= alu_data;
        end else if (pop_s) begin
            reg_write_r <= head_live_s;
            if (head_live_s) begin
                rd_r         <= head_rd_s;
                write_data_r <= head_data_s;
            end else begin
                rd_r         <= rd_r;
                write_data_r <= write_data_r;
            end
        end else begin
            reg_write_r <= 1'b0;
        end
    end

    assign ld_ready   = ld_ready_s;
    assign rd         = rd_r;
    assign write_data = write_data_r;
    assign RegWrite   = reg_write_r;
    assign wb_idle    = (count_s == {(PW+1){1'b0}}) && !reg_write_r;

endmodule
